i2c_xfer_sequencer: RTL and testbench
=====================================

// Module: i2c_xfer_sequencer
// PURPOSE
//  Turns single-byte I2C register commands into the AXI4-Lite register accesses that drive the axi_i2c_bridge.
//  The bridge's register file is PRERlo/PRERhi/CTR/TXR-RXR/CR-SR at index 0..4.
//  Sits between a local command client and the bridge's AXI slave port, and is the only master on that port.
//  Programs the prescaler and enables the core once after reset, then sequences START/WR/RD/STOP per command.
//  Polls SR.TIP between byte phases and reports status.
// PARAMETERS
//  C_AXI_DATA_WIDTH  32    AXI data width; fixed at 32.
//  C_AXI_ADDR_WIDTH  28    AXI address width.
//  BASE_ADDR         28'h0 AXI byte address of register index 0.
//  REG_STRIDE        1     Byte stride between register indices; reg addr = BASE_ADDR + idx*REG_STRIDE.
//  PRESCALE          16'd99 Value written to PRERlo/PRERhi at init.
//  POLL_LIMIT        1024  Max SR reads per TIP wait before timeout.
// PORTS
//  clk          in   1   System clock.
//  rst          in   1   Synchronous, active-high reset.
//  cmd_valid    in   1   Command request.
//  cmd_ready    out  1   High only in IDLE; accept on cmd_valid&cmd_ready.
//  cmd_rd       in   1   1 = register read, 0 = register write.
//  cmd_dev      in   7   I2C 7-bit device address.
//  cmd_reg      in   8   Device register address.
//  cmd_wdata    in   8   Write data; ignored for reads.
//  rsp_valid    out  1   One-cycle pulse at command completion; no backpressure.
//  rsp_rdata    out  8   Read byte; 0 for writes and on error.
//  rsp_err      out  2   00 ok, 01 NACK, 10 AXI SLVERR/DECERR, 11 poll timeout.
//  m_axi_aw*/w*/b*      AXI-Lite write master (awvalid, awready, awaddr, awprot=3'b000, wvalid, wready, wdata, wstrb, bvalid, bready, bresp).
//  m_axi_ar*/r*         AXI-Lite read master (arvalid, arready, araddr, arprot=3'b000, rvalid, rready, rdata, rresp).
// BEHAVIOUR
//  Reset: all outputs 0, FSM->INIT; an in-flight AXI transaction is abandoned.
//   The bridge must be reset in the same cycle.
//  Write access: awvalid and wvalid asserted together, each dropped independently on its ready.
//   wdata = byte replicated on all 4 lanes; wstrb = 4'b0001 << addr[1:0].
//   bready=1 only after both handshakes; bresp!=0 -> err 10.
//  Read access: arvalid until arready, then rready=1; byte taken from lane araddr[1:0]; rresp!=0 -> err 10.
//  Only one AXI transaction is outstanding at any time; AXI inputs are registered before use.
//  INIT: PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=0x80 -> IDLE.
//   An INIT AXI error re-runs INIT; no rsp is issued.
//  IDLE: cmd_ready=1. Fields are latched on accept; cmd_ready=0 from the next cycle.
//  Phase = write TXR, write CR, then POLL: read SR until SR[1] (TIP)=0.
//   POLL_LIMIT reads with TIP=1 -> err 11.
//   After the poll, SR[7] (RxACK)=1 on any address/data write phase -> NACK_STOP.
//  WRITE cmd phases: {dev,0}/CR 0x90; reg/CR 0x10; wdata/CR 0x50 (WR|STO).
//  READ cmd phases: {dev,0}/0x90; reg/0x10; {dev,1}/0x90 (repeated START).
//   Then CR=0x68 (RD|ACK=NACK|STO) with no TXR write, poll, read RXR -> rsp_rdata.
//  NACK_STOP: write CR=0x40 (STO), poll TIP, then RESP with err 01.
//  Error 10/11: go to RESP directly, then INIT before the next IDLE.
//   rsp is issued before re-init.
//  RESP: rsp_valid=1 for exactly one cycle, rsp_* valid that cycle -> IDLE (or INIT after error 10/11).
//  Latency: cmd accept -> rsp depends on AXI and I2C timing.
//   cmd_valid arriving during INIT is held off (cmd_ready=0).
//  A command must not be dropped; back-to-back commands are accepted the cycle after rsp_valid.
// TESTING
//  Bench = this block + axi_i2c_bridge + i2c_slave model at dev 0x10, PRESCALE=4, POLL_LIMIT=1024.
//  T1 Reset release -> exactly 3 AXI writes: idx0=0x04, idx1=0x00, idx2=0x80; then cmd_ready=1.
//  T2 Write dev 0x10 reg 0x01 data 0xA5 -> rsp_err=00.
//   A following read of reg 0x01 -> rsp_rdata=0xA5, err=00.
//  T3 Write to dev 0x22 (absent) -> SR.RxACK=1 after address -> CR=0x40 issued, rsp_err=01, no data phase.
//  T4 Force bresp=2'b10 on the 2nd command write -> rsp_err=10 -> INIT re-run (3 writes) before cmd_ready.
//  T5 Hold SCL low externally -> 1024 SR reads with TIP=1 -> rsp_err=11, rsp_rdata=0.
//  T6 Assert rst mid-read (during POLL) -> all outputs 0 next cycle.
//   Clean INIT on release; next command completes ok.
//  Checkers: one outstanding AXI transaction; valids stable until ready; rsp_valid one cycle per accepted cmd.

Source files
------------

// File: rtl/i2c_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_xfer_sequencer
//
// Purpose:
//   Converts single-byte I2C register commands into the AXI4-Lite register
//   accesses that drive an OpenCores-style I2C master bridge. The bridge
//   register file is PRERlo/PRERhi/CTR/TXR-RXR/CR-SR at index 0..4.
//   After reset the prescaler is programmed and the core enabled. Each
//   command is then sequenced as START/WR/RD/STOP byte phases. SR.TIP is
//   polled between phases, and one response is returned per command.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_rd                1 = register read, 0 = register write
//   cmd_dev/reg/wdata     7-bit device address, register address, write byte
//   rsp_valid             one-cycle completion pulse (no backpressure)
//   rsp_rdata             read byte (0 for writes and on error)
//   rsp_err               00 ok, 01 NACK, 10 AXI error, 11 poll timeout
//   m_axi_aw*/w*/b*       AXI4-Lite write master
//   m_axi_ar*/r*          AXI4-Lite read master
// -----------------------------------------------------------------------------
module i2c_xfer_sequencer #(
   parameter int                          C_AXI_DATA_WIDTH = 32,
   parameter int                          C_AXI_ADDR_WIDTH = 28,
   parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
   parameter int                          REG_STRIDE       = 1,
   parameter logic [15:0]                 PRESCALE         = 16'd99,
   parameter int                          POLL_LIMIT       = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_rd,
   input  logic [6:0]                    cmd_dev,
   input  logic [7:0]                    cmd_reg,
   input  logic [7:0]                    cmd_wdata,
   output logic                          rsp_valid,
   output logic [7:0]                    rsp_rdata,
   output logic [1:0]                    rsp_err,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp
);

   localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
   localparam int POLL_W = $clog2(POLL_LIMIT + 1);

   // Bridge register indices (TXR/RXR and CR/SR share an index).
   localparam logic [2:0] IDX_CTR = 3'd2;
   localparam logic [2:0] IDX_TXR = 3'd3;
   localparam logic [2:0] IDX_CR  = 3'd4;

   // CR command bytes: STA=0x80 STO=0x40 RD=0x20 WR=0x10 ACK=0x08.
   localparam logic [7:0] CR_STA_WR   = 8'h90;
   localparam logic [7:0] CR_WR       = 8'h10;
   localparam logic [7:0] CR_WR_STO   = 8'h50;
   localparam logic [7:0] CR_RD_NSTO  = 8'h68;
   localparam logic [7:0] CR_STO      = 8'h40;
   localparam logic [7:0] CTR_EN      = 8'h80;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_NACK = 2'b01;
   localparam logic [1:0] ERR_AXI  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR, S_NSTOP_CR, S_NSTOP_POLL, S_RESP
   } state_t;

   // AXI access engine: one access in flight at a time, the result is
   // captured into registers and consumed by the sequencer in A_DONE.
   typedef enum logic [2:0] {A_IDLE, A_WR, A_B, A_AR, A_R, A_DONE} acc_t;

   state_t              state;
   acc_t                acc_st;
   logic                rd_q;
   logic [6:0]          dev_q;
   logic [7:0]          reg_q;
   logic [7:0]          wdata_q;
   logic [1:0]          phase_q;      // byte phase within the command
   logic [1:0]          init_step_q;  // PRERlo, PRERhi, CTR
   logic [POLL_W-1:0]   poll_cnt_q;
   logic                reinit_q;     // re-run INIT after the response
   logic [1:0]          resp_q;       // captured bresp/rresp
   logic [7:0]          rbyte_q;      // captured read byte

   // Access target for the current state.
   logic                        acc_rd;
   logic [2:0]                  acc_idx;
   logic [7:0]                  acc_byte;
   logic [C_AXI_ADDR_WIDTH-1:0] acc_addr;
   logic                        acc_needed;
   logic                        last_phase;
   logic                        read_phase;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   assign acc_addr   = BASE_ADDR + C_AXI_ADDR_WIDTH'(acc_idx) * C_AXI_ADDR_WIDTH'(REG_STRIDE);
   assign acc_needed = (state != S_IDLE) && (state != S_RESP);
   // Reads end with a receive phase (3); writes end after the data byte (2).
   assign read_phase = rd_q && (phase_q == 2'd3);
   assign last_phase = rd_q ? (phase_q == 2'd3) : (phase_q == 2'd2);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      acc_rd   = 1'b0;
      acc_idx  = IDX_CR;
      acc_byte = 8'h00;
      case (state)
         S_INIT: begin
            acc_idx = {1'b0, init_step_q};
            case (init_step_q)
               2'd0:    acc_byte = PRESCALE[7:0];
               2'd1:    acc_byte = PRESCALE[15:8];
               default: acc_byte = CTR_EN;
            endcase
            if (init_step_q == 2'd3) acc_idx = IDX_CTR;
         end
         S_TXR: begin
            acc_idx = IDX_TXR;
            case (phase_q)
               2'd0:    acc_byte = {dev_q, 1'b0};
               2'd1:    acc_byte = reg_q;
               default: acc_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
            endcase
         end
         S_CR: begin
            case (phase_q)
               2'd0:    acc_byte = CR_STA_WR;
               2'd1:    acc_byte = CR_WR;
               2'd2:    acc_byte = rd_q ? CR_STA_WR : CR_WR_STO;
               default: acc_byte = CR_RD_NSTO;
            endcase
         end
         S_NSTOP_CR:             acc_byte = CR_STO;
         S_POLL, S_NSTOP_POLL:   acc_rd   = 1'b1;
         S_RXR: begin
            acc_rd  = 1'b1;
            acc_idx = IDX_TXR;
         end
         default: ;
      endcase
   end

   task automatic respond(input logic [1:0] err, input logic [7:0] data);
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= data;
      reinit_q  <= err[1];
      state     <= S_RESP;
   endtask

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_INIT;
         acc_st        <= A_IDLE;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= 8'h00;
         rsp_err       <= 2'b00;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_rready  <= 1'b0;
         rd_q          <= 1'b0;
         dev_q         <= '0;
         reg_q         <= '0;
         wdata_q       <= '0;
         phase_q       <= '0;
         init_step_q   <= '0;
         poll_cnt_q    <= '0;
         reinit_q      <= 1'b0;
         resp_q        <= '0;
         rbyte_q       <= '0;
      end else begin
         // ---------------- AXI access engine ----------------
         case (acc_st)
            A_IDLE: if (acc_needed) begin
               if (acc_rd) begin
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= acc_addr;
                  acc_st        <= A_AR;
               end else begin
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_awaddr  <= acc_addr;
                  m_axi_wdata   <= {STRB_W{acc_byte}};
                  m_axi_wstrb   <= STRB_W'(1'b1) << acc_addr[1:0];
                  acc_st        <= A_WR;
               end
            end
            A_WR: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
               // Both channels done (earlier or on this edge): open B.
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  m_axi_bready <= 1'b1;
                  acc_st       <= A_B;
               end
            end
            A_B: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               resp_q       <= m_axi_bresp;
               acc_st       <= A_DONE;
            end
            A_AR: if (m_axi_arready) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready  <= 1'b1;
               acc_st        <= A_R;
            end
            A_R: if (m_axi_rvalid) begin
               m_axi_rready <= 1'b0;
               resp_q       <= m_axi_rresp;
               rbyte_q      <= m_axi_rdata[{m_axi_araddr[1:0], 3'b000} +: 8];
               acc_st       <= A_DONE;
            end
            default: acc_st <= A_IDLE;
         endcase

         // ---------------- command sequencer ----------------
         case (state)
            S_IDLE: if (cmd_valid && cmd_ready) begin
               cmd_ready <= 1'b0;
               rd_q      <= cmd_rd;
               dev_q     <= cmd_dev;
               reg_q     <= cmd_reg;
               wdata_q   <= cmd_wdata;
               phase_q   <= 2'd0;
               state     <= S_TXR;
            end
            S_RESP: begin
               rsp_valid <= 1'b0;
               if (reinit_q) begin
                  init_step_q <= 2'd0;
                  state       <= S_INIT;
               end else begin
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: if (acc_st == A_DONE) begin
               if (resp_q != 2'b00) begin
                  if (state == S_INIT) init_step_q <= 2'd0;
                  else                 respond(ERR_AXI, 8'h00);
               end else begin
                  case (state)
                     S_INIT: begin
                        if (init_step_q == 2'd2) begin
                           cmd_ready <= 1'b1;
                           state     <= S_IDLE;
                        end else begin
                           init_step_q <= init_step_q + 2'd1;
                        end
                     end
                     S_TXR: state <= S_CR;
                     S_CR: begin
                        poll_cnt_q <= '0;
                        state      <= S_POLL;
                     end
                     S_POLL: begin
                        if (rbyte_q[1]) begin
                           if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) respond(ERR_TMO, 8'h00);
                           else poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                        end else if (!read_phase && rbyte_q[7]) begin
                           state <= S_NSTOP_CR;
                        end else if (last_phase) begin
                           if (rd_q) state <= S_RXR;
                           else      respond(ERR_OK, 8'h00);
                        end else begin
                           phase_q <= phase_q + 2'd1;
                           // The receive phase has no TXR write.
                           state   <= (rd_q && phase_q == 2'd2) ? S_CR : S_TXR;
                        end
                     end
                     S_RXR: respond(ERR_OK, rbyte_q);
                     S_NSTOP_CR: begin
                        poll_cnt_q <= '0;
                        state      <= S_NSTOP_POLL;
                     end
                     S_NSTOP_POLL: begin
                        if (rbyte_q[1]) begin
                           if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) respond(ERR_TMO, 8'h00);
                           else poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                        end else begin
                           respond(ERR_NACK, 8'h00);
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_xfer_sequencer
//
// Directed bench for i2c_xfer_sequencer. A behavioural AXI4-Lite slave
// stands in for the I2C bridge register file plus an I2C slave at device
// 0x10. The bridge holds TIP for two SR reads after each byte command, or
// indefinitely while scl_hold is set. The model also logs every register
// write and counts protocol violations seen on the master.
// -----------------------------------------------------------------------------
module tb_i2c_xfer_sequencer;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_rd;
   logic [6:0]  cmd_dev;
   logic [7:0]  cmd_reg, cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_err;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [27:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   i2c_xfer_sequencer #(.PRESCALE(16'd4), .POLL_LIMIT(1024)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
      .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awprot(awprot), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready), .m_axi_bresp(bresp), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
      .m_axi_rresp(rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bridge + I2C slave model ----------------
   int          inject_at;    // write ordinal that gets bresp=SLVERR
   bit          scl_hold;     // SCL held low: TIP never clears
   int          wr_count, sr_tip_reads, sto_writes, txr_writes, proto_viol;
   logic [2:0]  wlog_idx [0:1023];
   logic [7:0]  wlog_dat [0:1023];
   logic [7:0]  mem [0:255];
   logic        aw_got, w_got, rxack, addressed, aw_hold, w_hold, ar_hold;
   logic [27:0] aw_a, aw_hold_a, ar_hold_a;
   logic [31:0] w_d, w_hold_d;
   logic [3:0]  w_s;
   logic [7:0]  txr, rxr, reg_ptr;
   int          tip_cnt, byte_no;

   function automatic logic [7:0] lane_get(input logic [31:0] d, input logic [1:0] l);
      return d[8*l +: 8];
   endfunction

   function automatic logic [31:0] lane_put(input logic [7:0] b, input logic [1:0] l);
      logic [31:0] d;
      d = 32'hEEEE_EEEE;
      d[8*l +: 8] = b;
      return d;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
         arready <= 0; rvalid <= 0; rdata <= 0; rresp <= 0;
         aw_got <= 0; w_got <= 0; tip_cnt <= 0; rxack <= 0; addressed <= 0;
         aw_hold <= 0; w_hold <= 0; ar_hold <= 0;
      end else begin
         // Master-side protocol monitors.
         if ((awvalid || wvalid || bready) && (arvalid || rready)) proto_viol <= proto_viol + 1;
         if (aw_hold && (!awvalid || awaddr != aw_hold_a)) proto_viol <= proto_viol + 1;
         if (w_hold && (!wvalid || wdata != w_hold_d)) proto_viol <= proto_viol + 1;
         if (ar_hold && (!arvalid || araddr != ar_hold_a)) proto_viol <= proto_viol + 1;
         aw_hold <= awvalid && !awready; aw_hold_a <= awaddr;
         w_hold  <= wvalid && !wready;   w_hold_d  <= wdata;
         ar_hold <= arvalid && !arready; ar_hold_a <= araddr;

         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
         // AW accepted first; W a couple of cycles later.
         if (awvalid && !awready && !aw_got) awready <= 1'b1;
         if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
         if (wvalid && !wready && !w_got && aw_got) wready <= 1'b1;
         if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
         if (aw_got && w_got && !bvalid) begin
            automatic logic [7:0] b = lane_get(w_d, aw_a[1:0]);
            if (w_s != (4'b0001 << aw_a[1:0]) || w_d != {4{b}}) proto_viol <= proto_viol + 1;
            wlog_idx[wr_count[9:0]] <= aw_a[2:0];
            wlog_dat[wr_count[9:0]] <= b;
            wr_count <= wr_count + 1;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= (wr_count == inject_at) ? 2'b10 : 2'b00;
            if (aw_a[2:0] == 3'd3) begin txr <= b; txr_writes <= txr_writes + 1; end
            if (aw_a[2:0] == 3'd4) begin
               if (b == 8'h40) sto_writes <= sto_writes + 1;
               if (b[4]) begin
                  tip_cnt <= 2;
                  if (b[7]) begin
                     addressed <= (txr[7:1] == 7'h10);
                     rxack     <= (txr[7:1] != 7'h10);
                     byte_no   <= 0;
                  end else if (addressed) begin
                     rxack <= 1'b0;
                     if (byte_no == 0) reg_ptr <= txr;
                     else begin mem[reg_ptr] <= txr; reg_ptr <= reg_ptr + 8'd1; end
                     byte_no <= byte_no + 1;
                  end else rxack <= 1'b1;
               end else if (b[5]) begin
                  tip_cnt <= 2;
                  rxr     <= addressed ? mem[reg_ptr] : 8'hFF;
                  reg_ptr <= reg_ptr + 8'd1;
               end
            end
         end
         if (bvalid && bready) bvalid <= 1'b0;

         if (arvalid && !arready && !rvalid) arready <= 1'b1;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rresp  <= 2'b00;
            if (araddr[2:0] == 3'd4) begin
               rdata <= lane_put({rxack, 5'b0, scl_hold || tip_cnt != 0, 1'b0}, araddr[1:0]);
               if (scl_hold || tip_cnt != 0) sr_tip_reads <= sr_tip_reads + 1;
               if (tip_cnt != 0) tip_cnt <= tip_cnt - 1;
            end else begin
               rdata <= lane_put(rxr, araddr[1:0]);
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      bit seen = 0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         if (cmd_ready) seen = 1;
         else @(negedge clk);
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_init(input string tag, input int b);
      check({tag, "_idx0"}, 32'(wlog_idx[10'(b)]),     32'd0);
      check({tag, "_dat0"}, 32'(wlog_dat[10'(b)]),     32'h04);
      check({tag, "_idx1"}, 32'(wlog_idx[10'(b + 1)]), 32'd1);
      check({tag, "_dat1"}, 32'(wlog_dat[10'(b + 1)]), 32'h00);
      check({tag, "_idx2"}, 32'(wlog_idx[10'(b + 2)]), 32'd2);
      check({tag, "_dat2"}, 32'(wlog_dat[10'(b + 2)]), 32'h80);
   endtask

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic do_cmd(input string tag, input logic rd, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd,
                         output logic [7:0] rd_byte, output logic [1:0] err);
      bit acc = 0;
      bit got = 0;
      rd_byte = 8'h00;
      err     = 2'b00;
      cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
      for (int i = 0; i < 5000 && !acc; i++) begin
         if (cmd_ready) acc = 1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check({tag, "_accept"}, 32'(acc), 32'd1);
      check({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 30000 && !got; i++) begin
         if (rsp_valid) begin got = 1; rd_byte = rsp_rdata; err = rsp_err; end
         @(negedge clk);
      end
      check({tag, "_rsp"}, 32'(got), 32'd1);
      check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(cmd_ready), 32'(!err[1]));
   endtask

   logic [7:0] r_byte;
   logic [1:0] r_err;
   int         base, base2;
   bit         hit;

   initial begin
      cmd_valid = 0; cmd_rd = 0; cmd_dev = '0; cmd_reg = '0; cmd_wdata = '0;
      inject_at = -1; scl_hold = 0;
      wr_count = 0; sr_tip_reads = 0; sto_writes = 0; txr_writes = 0; proto_viol = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
      check("reset_data", 32'(|{rsp_rdata, rsp_err, awaddr, wdata, wstrb, araddr, awprot, arprot}), 32'd0);

      // T1: init programming after reset release.
      base = wr_count;
      rst = 1'b0;
      wait_ready("t1_ready");
      check("t1_wr_count", 32'(wr_count - base), 32'd3);
      check_init("t1", base);

      // T2: write then read back, two data patterns, back-to-back.
      base2 = txr_writes;
      do_cmd("t2_wr1", 1'b0, 7'h10, 8'h01, 8'hA5, r_byte, r_err);
      check("t2_wr1_err", 32'(r_err), 32'd0);
      check("t2_wr1_rdata", 32'(r_byte), 32'd0);
      check("t2_wr1_txr", 32'(txr_writes - base2), 32'd3);
      do_cmd("t2_rd1", 1'b1, 7'h10, 8'h01, 8'h00, r_byte, r_err);
      check("t2_rd1_err", 32'(r_err), 32'd0);
      check("t2_rd1_rdata", 32'(r_byte), 32'hA5);
      do_cmd("t2_wr2", 1'b0, 7'h10, 8'h02, 8'h3C, r_byte, r_err);
      check("t2_wr2_err", 32'(r_err), 32'd0);
      do_cmd("t2_rd2", 1'b1, 7'h10, 8'h02, 8'h00, r_byte, r_err);
      check("t2_rd2_rdata", 32'(r_byte), 32'h3C);

      // T3: absent device -> NACK, STOP issued, no data phase.
      base  = sto_writes;
      base2 = txr_writes;
      do_cmd("t3", 1'b0, 7'h22, 8'h05, 8'h77, r_byte, r_err);
      check("t3_err", 32'(r_err), 32'd1);
      check("t3_rdata", 32'(r_byte), 32'd0);
      check("t3_sto", 32'(sto_writes - base), 32'd1);
      check("t3_txr", 32'(txr_writes - base2), 32'd1);

      // T4: SLVERR on the 2nd write of a command -> err 10 then re-init.
      base = wr_count;
      inject_at = base + 1;
      do_cmd("t4", 1'b0, 7'h10, 8'h03, 8'h11, r_byte, r_err);
      inject_at = -1;
      check("t4_err", 32'(r_err), 32'd2);
      check("t4_rdata", 32'(r_byte), 32'd0);
      wait_ready("t4_ready");
      check("t4_wr_count", 32'(wr_count - base), 32'd5);
      check_init("t4", base + 2);

      // T5: SCL held low -> POLL_LIMIT TIP reads then timeout.
      scl_hold = 1'b1;
      base = sr_tip_reads;
      do_cmd("t5", 1'b0, 7'h10, 8'h04, 8'h22, r_byte, r_err);
      scl_hold = 1'b0;
      check("t5_err", 32'(r_err), 32'd3);
      check("t5_rdata", 32'(r_byte), 32'd0);
      check("t5_tip_reads", 32'(sr_tip_reads - base), 32'd1024);
      base = wr_count;
      wait_ready("t5_ready");
      check_init("t5", base);

      // T6: reset during a read's SR poll.
      cmd_rd = 1'b1; cmd_dev = 7'h10; cmd_reg = 8'h01; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         if (arvalid && araddr == 28'd4) hit = 1;
         else @(negedge clk);
      end
      check("t6_poll_seen", 32'(hit), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_ctrl", 32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
      check("t6_rst_data", 32'(|{rsp_rdata, rsp_err, awaddr, wdata, wstrb, araddr}), 32'd0);
      base = wr_count;
      rst = 1'b0;
      wait_ready("t6_ready");
      check("t6_wr_count", 32'(wr_count - base), 32'd3);
      check_init("t6", base);
      do_cmd("t6_rd", 1'b1, 7'h10, 8'h01, 8'h00, r_byte, r_err);
      check("t6_rd_err", 32'(r_err), 32'd0);
      check("t6_rd_rdata", 32'(r_byte), 32'hA5);

      check("axi_protocol", 32'(proto_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
